// File: rtl/snake_pkg.sv
// Shared direction codes, grid defaults and heading helpers for the snake datapath.
package snake_pkg;

  localparam logic [5:0] DIR_LEFT  = 6'b000001;
  localparam logic [5:0] DIR_RIGHT = 6'b000010;
  localparam logic [5:0] DIR_UP    = 6'b000100;
  localparam logic [5:0] DIR_DOWN  = 6'b001000;

  localparam int unsigned GRID_W_DEFAULT = 40;
  localparam int unsigned GRID_H_DEFAULT = 30;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // True only for exactly one of the four legal one-hot codes.
  function automatic logic dir_valid(input logic [5:0] d);
    logic ok;
    case (d)
      DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Opposite heading; illegal codes map to zero so they never match a heading.
  function automatic logic [5:0] dir_opposite(input logic [5:0] d);
    logic [5:0] opp;
    case (d)
      DIR_LEFT:  opp = DIR_RIGHT;
      DIR_RIGHT: opp = DIR_LEFT;
      DIR_UP:    opp = DIR_DOWN;
      DIR_DOWN:  opp = DIR_UP;
      default:   opp = 6'b000000;
    endcase
    return opp;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled cycles, frozen when en is low.
module tick_gen #(
  parameter int unsigned DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count and tick; tick is only raised on a cycle that actually counts.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Steps the snake head one cell per game tick with reversal rejection and edge wrap.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = GRID_W_DEFAULT,
  parameter int unsigned GRID_H   = GRID_H_DEFAULT,
  parameter int unsigned XW       = 6,
  parameter int unsigned YW       = 5,
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [5:0]    direction,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [5:0]    heading,
  output logic          step
);

  localparam logic [XW-1:0] X_MAX  = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_INIT = XW'(START_X);
  localparam logic [YW-1:0] Y_INIT = YW'(START_Y);

  state_e        state_q, state_d;
  logic          tick;
  logic          count_en;
  logic          accept;
  logic [5:0]    new_heading;
  logic [XW-1:0] head_x_q, head_x_d;
  logic [YW-1:0] head_y_q, head_y_d;
  logic [5:0]    heading_q, heading_d;
  logic          step_q;

  // Counting is qualified by enable in the same cycle: the edge that leaves IDLE already
  // counts, and a tick landing on the edge where enable falls is never raised.
  assign count_en = enable;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_en),
    .tick  (tick)
  );

  // Run/pause state transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable)  state_d = StRun;
      StRun:   if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Heading arbitration and wrapped one-cell move, applied only on tick.
  always_comb begin
    accept      = dir_valid(direction) && (direction != dir_opposite(heading_q));
    new_heading = accept ? direction : heading_q;
    heading_d   = heading_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    if (tick) begin
      heading_d = new_heading;
      case (new_heading)
        DIR_RIGHT: head_x_d = (head_x_q == X_MAX) ? '0 : head_x_q + XW'(1);
        DIR_LEFT:  head_x_d = (head_x_q == '0) ? X_MAX : head_x_q - XW'(1);
        DIR_DOWN:  head_y_d = (head_y_q == Y_MAX) ? '0 : head_y_q + YW'(1);
        DIR_UP:    head_y_d = (head_y_q == '0) ? Y_MAX : head_y_q - YW'(1);
        default:   ;
      endcase
    end
  end

  // State, head, heading and step registers; reset overrides any tick in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      head_x_q  <= X_INIT;
      head_y_q  <= Y_INIT;
      heading_q <= DIR_RIGHT;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_x_q  <= head_x_d;
      head_y_q  <= head_y_d;
      heading_q <= heading_d;
      step_q    <= tick;
    end
  end

  assign head_x  = head_x_q;
  assign head_y  = head_y_q;
  assign heading = heading_q;
  assign step    = step_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper with a cycle-level reference model.
module tb_snake_head_stepper;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int DIV = 4;
  localparam int SX  = 3;
  localparam int SY  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [5:0] direction;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic [5:0] heading;
  logic       step;

  int checks = 0;
  int errors = 0;

  snake_head_stepper #(
    .GRID_W   (W),
    .GRID_H   (H),
    .XW       (3),
    .YW       (3),
    .TICK_DIV (DIV),
    .START_X  (SX),
    .START_Y  (SY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .direction (direction),
    .head_x    (head_x),
    .head_y    (head_y),
    .heading   (heading),
    .step      (step)
  );

  always #5 clk = ~clk;

  // Model state: heading index 0=left 1=right 2=up 3=down; opposite is index ^ 1.
  int  mx, my, mh, run_cycles;
  bit  mstep;
  bit  model_valid = 1'b0;

  function automatic int dir_index(input logic [5:0] d);
    case (d)
      6'b000001: return 0;
      6'b000010: return 1;
      6'b000100: return 2;
      6'b001000: return 3;
      default:   return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    int idx;
    if (!rst_n) begin
      mx = SX; my = SY; mh = 1; mstep = 0; run_cycles = 0;
    end else begin
      mstep = 0;
      if (enable) begin
        run_cycles++;
        if (run_cycles % DIV == 0) begin
          idx = dir_index(direction);
          if (idx >= 0 && idx != (mh ^ 1)) mh = idx;
          case (mh)
            0: mx = (mx + W - 1) % W;
            1: mx = (mx + 1) % W;
            2: my = (my + H - 1) % H;
            default: my = (my + 1) % H;
          endcase
          mstep = 1;
        end
      end
    end
    model_valid = 1'b1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model head_x", int'(head_x), mx);
      check("model head_y", int'(head_y), my);
      check("model heading", int'(heading), 1 << mh);
      check("model step", int'(step), int'(mstep));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; direction = 6'b000000;
    cyc(2);
    check("reset head_x", int'(head_x), 3);
    check("reset head_y", int'(head_y), 2);
    check("reset heading", int'(heading), 2);
    check("reset step", int'(step), 0);

    // Free run right: steps every 4 cycles.
    rst_n = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(3);
      check("run no early step", int'(step), 0);
      cyc(1);
      check("run step", int'(step), 1);
      check("run head_x", int'(head_x), 3 + k);
      check("run head_y", int'(head_y), 2);
    end

    // Reversal rejected, then wrap right 7 -> 0.
    direction = 6'b000001;
    cyc(4);
    check("reversal heading", int'(heading), 2);
    check("reversal head_x", int'(head_x), 7);
    direction = 6'b000000;
    cyc(4);
    check("wrap right head_x", int'(head_x), 0);

    // Down through bottom wrap to row 0.
    direction = 6'b001000;
    cyc(16);
    check("wrap down head_y", int'(head_y), 0);
    check("down heading", int'(heading), 8);

    // Left at x=0 wraps to 7.
    direction = 6'b000001;
    cyc(4);
    check("wrap left head_x", int'(head_x), 7);
    check("left heading", int'(heading), 1);

    // Up at y=0 wraps to 5.
    direction = 6'b000100;
    cyc(4);
    check("wrap up head_y", int'(head_y), 5);
    check("up heading", int'(heading), 4);

    // Illegal codes ignored; opposite code rejected.
    direction = 6'b000011;
    cyc(4);
    check("multi-hot heading", int'(heading), 4);
    check("multi-hot head_y", int'(head_y), 4);
    direction = 6'b010000;
    cyc(4);
    check("high-bit heading", int'(heading), 4);
    check("high-bit head_y", int'(head_y), 3);
    direction = 6'b001000;
    cyc(4);
    check("up-down reject heading", int'(heading), 4);
    check("up-down reject head_y", int'(head_y), 2);

    // Pause at count 2, then next step exactly 2 cycles after re-enable.
    direction = 6'b000000;
    cyc(2);
    enable = 1'b0;
    cyc(10);
    check("pause head_y", int'(head_y), 2);
    check("pause step", int'(step), 0);
    enable = 1'b1;
    cyc(1);
    check("resume no step", int'(step), 0);
    cyc(1);
    check("resume step", int'(step), 1);
    check("resume head_y", int'(head_y), 1);

    // Tick coinciding with enable falling is discarded.
    cyc(3);
    enable = 1'b0;
    cyc(1);
    check("drop tick step", int'(step), 0);
    check("drop tick head_y", int'(head_y), 1);
    enable = 1'b1;
    cyc(1);
    check("held tick step", int'(step), 1);
    check("held tick head_y", int'(head_y), 0);

    // Reset in the same cycle as a tick wins.
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    check("reset-tick head_x", int'(head_x), 3);
    check("reset-tick head_y", int'(head_y), 2);
    check("reset-tick heading", int'(heading), 2);
    check("reset-tick step", int'(step), 0);
    rst_n = 1'b1;
    cyc(4);
    check("post-reset step", int'(step), 1);
    check("post-reset head_x", int'(head_x), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_head_stepper.md
Name: snake_head_stepper

Overview:
- Downstream of the keypad direction register; consumes its registered 6-bit one-hot direction code.
- Advances the snake head one grid cell per game tick, rejects 180-degree reversals and wraps at the playfield edges.
- Produces head coordinates, the committed heading and a one-cycle step strobe for the body/collision and VGA stages.

Parameters:
- GRID_W, 40, playfield width in cells.
- GRID_H, 30, playfield height in cells.
- XW, 6, head_x width; must satisfy 2**XW >= GRID_W.
- YW, 5, head_y width; must satisfy 2**YW >= GRID_H.
- TICK_DIV, 5000000, clk cycles per head step; minimum 2.
- START_X, 20, head_x after reset.
- START_Y, 15, head_y after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  game running; low pauses stepping
- direction  in  6  requested heading, one-hot: 000001 left, 000010 right, 000100 up, 001000 down
- head_x  out  XW  current head column
- head_y  out  YW  current head row, 0 = top
- heading  out  6  committed heading, same encoding as direction
- step  out  1  one-cycle pulse, high in the cycle after head_x/head_y/heading change

Behaviour:
- Reset: one clock and one synchronous active-low reset; rst_n is sampled on posedge clk only.
  - Reset values: head_x=START_X, head_y=START_Y, heading=000010 (right), step=0, tick counter=0, state=IDLE.
  - Reset asserted mid-operation wins over every other event in that cycle.
- Tick counter: width $clog2(TICK_DIV).
  - In RUN it increments each cycle.
  - At TICK_DIV-1 it returns to 0 and raises the internal tick for that cycle.
- States:
  - IDLE -> RUN when enable=1. The counter starts from its held value.
  - RUN -> IDLE when enable=0. The counter freezes and is not cleared.
  - No tick is raised in IDLE. A tick coinciding with enable falling is discarded.
- On tick, at posedge k:
  - The direction value sampled at edge k is the candidate.
  - The candidate is accepted only if it is exactly one of the four legal codes and not the opposite of the current heading. Opposite pairs: left/right, up/down.
  - Otherwise the heading holds. This covers 000000, multi-hot codes and any code with bits 5:4 set.
  - The new heading is committed and the head moves one cell in the new heading at the same edge k.
  - step=1 for the cycle following edge k, then returns to 0.
- Movement and wrap:
  - right: x==GRID_W-1 -> 0, else x+1.
  - left: x==0 -> GRID_W-1, else x-1.
  - down: y==GRID_H-1 -> 0, else y+1.
  - up: y==0 -> GRID_H-1, else y-1.
  - Only one axis changes per step. No arithmetic overflow past the grid bounds.
- Latency: head and heading outputs are registered, updated exactly TICK_DIV cycles apart while in RUN.
  - Requests changing between ticks: only the value present at the tick edge counts; intermediate values are lost by design.
- Outputs hold their values while paused. heading never takes a value outside the four legal codes.

Decomposition:
- Package snake_pkg:
  - DIR_LEFT/DIR_RIGHT/DIR_UP/DIR_DOWN 6-bit constants.
  - Default GRID_W/GRID_H.
  - dir_valid function (legal one-hot check).
  - dir_opposite function.
- Sub-module tick_gen (parameter DIV; ports clk, rst_n, en, tick).
  - Holds the prescaler so the VGA/food stages can reuse it.
- State register, heading logic and coordinate update stay in snake_head_stepper.

Test Plan (bench uses TICK_DIV=4, GRID_W=8, GRID_H=6, START_X=3, START_Y=2):
- Reset then enable=1, direction=000000 for 12 cycles -> three steps, head_x 4,5,6, head_y=2, heading=000010, step pulses spaced 4 cycles apart.
- Heading right, direction=000001 (left) at the tick -> reversal rejected; heading stays 000010 and head_x increments.
- direction=000100 (up) with head_y=0 -> heading=000100 and head_y wraps to 5; from head_x=7 heading right -> head_x=0.
- direction=000011, then 010000 at tick edges -> both ignored, heading unchanged, head still moves.
- enable dropped for 10 cycles mid-count (counter=2) -> no step, outputs hold; after re-enable the next step arrives exactly 2 cycles later.
- rst_n=0 in the same cycle as a tick -> head=(3,2), heading=000010, step=0 the next cycle, with no move applied.
